// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target exposing a bank of byte-wide registers to fabric logic. The bus
// is oversampled in the fabric clock domain: SCL/SDA are synchronized, glitch
// filtered, and edge detected. A register pointer is loaded by the first data
// byte of a write; later bytes are written with auto-increment. With
// I2C_TARGET_READBACK_EN defined, reads return regs[ptr] with auto-increment.
// Without it, a read address is NACKed.
//
// Parameters:
//   DEV_ADDR   7-bit target address
//   NUM_REGS   number of 8-bit registers (power of 2, 2..256)
//   FILTER_LEN consecutive equal samples needed to accept a level change
//
// Ports:
//   clk, rst              fabric clock, synchronous active-high reset
//   i2c_scl_i/_o/_t       SCL level in; never driven (both outputs tied 1)
//   i2c_sda_i/_o/_t       SDA level in; 0 pulls low, 1 releases (_t == _o)
//   regs_o                flat register bank, byte k at [8k+7:8k]
//   wr_strobe, wr_index   one-cycle pulse and index after each byte write
//   busy                  high from START until STOP
//
// Bus handshake: data bits are taken on the rising edge of filtered SCL and
// SDA is only ever changed one cycle after a falling edge of filtered SCL, so
// the target's SDA transitions always land inside the SCL-low phase.
// ---------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i2c_scl_i,
  output logic                        i2c_scl_o,
  output logic                        i2c_scl_t,
  input  logic                        i2c_sda_i,
  output logic                        i2c_sda_o,
  output logic                        i2c_sda_t,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_index,
  output logic                        busy
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(FILTER_LEN + 1);
`ifdef I2C_TARGET_READBACK_EN
  // Bit 7 of the shifter holds the next outgoing read bit.
  localparam int SW = 8;
`else
  // Only the 7 bits preceding the live SDA sample are ever needed.
  localparam int SW = 7;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_e;

  // ---------------- input conditioning ([1]=SCL, [0]=SDA) ----------------
  logic [1:0]    pin;
  logic [1:0]    sync0_q, sync1_q, filt_q, prev_q;
  logic [CW-1:0] fcnt_q [2];

  assign pin = {i2c_scl_i, i2c_sda_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 2'b11;
      sync1_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync0_q <= pin;
      sync1_q <= sync0_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the accepted level.
        if (sync1_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync1_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f    = filt_q[1];
  assign sda_f    = filt_q[0];
  assign scl_rise =  scl_f & ~prev_q[1];
  assign scl_fall = ~scl_f &  prev_q[1];
  // SCL must be high on both samples, so an SDA change that coincides with
  // an SCL edge is a data change, never START/STOP.
  assign start_det = scl_f & prev_q[1] & ~sda_f &  prev_q[0];
  assign stop_det  = scl_f & prev_q[1] &  sda_f & ~prev_q[0];

  // ---------------- protocol FSM ----------------
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          sda_q, sda_d;
  logic          busy_q, busy_d;
  logic          ack_rise_q, ack_rise_d;  // SCL high seen in current ACK slot
  logic          wr_strobe_q;
  logic [IW-1:0] wr_index_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic          wr_en;
  logic [7:0]    byte_in;
  logic          byte_done;
  logic          addr_hit;
`ifdef I2C_TARGET_READBACK_EN
  logic          rw_q, rw_d;
  logic [7:0]    rd_byte;
  assign rd_byte = regs_q[ptr_q[IW-1:0]];
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    ack_rise_d = ack_rise_q;
    wr_en      = 1'b0;
`ifdef I2C_TARGET_READBACK_EN
    rw_d       = rw_q;
`endif
    byte_in    = {shift_q[6:0], sda_f};
    byte_done  = scl_rise && (bit_cnt_q == 3'd7);
`ifdef I2C_TARGET_READBACK_EN
    addr_hit   = (byte_in[7:1] == DEV_ADDR);
`else
    addr_hit   = (byte_in[7:1] == DEV_ADDR) && !byte_in[0];
`endif

    if (stop_det) begin
      state_d = S_IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      // Pointer deliberately kept so a repeated START can read from it.
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd0;
      sda_d      = 1'b1;
      busy_d     = 1'b1;
      ack_rise_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[SW-1:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (byte_done) begin
            ack_rise_d = 1'b0;
            if (state_q == S_ADDR) begin
              if (addr_hit) begin
                state_d = S_ADDR_ACK;
`ifdef I2C_TARGET_READBACK_EN
                rw_d    = byte_in[0];
`endif
              end else begin
                state_d = S_IDLE;
                sda_d   = 1'b1;
              end
            end else if (state_q == S_PTR) begin
              ptr_d   = byte_in;
              state_d = S_PTR_ACK;
            end else begin
              wr_en   = 1'b1;
              ptr_d   = ptr_q + 8'd1;
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          // First SCL fall drives ACK, the rise marks the slot, the next
          // fall ends it.
          if (scl_rise) begin
            ack_rise_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_d = 1'b0;
            end else begin
              sda_d      = 1'b1;
              ack_rise_d = 1'b0;
              bit_cnt_d  = 3'd0;
              state_d    = (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
`ifdef I2C_TARGET_READBACK_EN
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_d = S_RDATA;
                sda_d   = rd_byte[7];
                shift_d = {rd_byte[6:0], 1'b0};
              end
`endif
            end
          end
        end
`ifdef I2C_TARGET_READBACK_EN
        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
              ptr_d      = ptr_q + 8'd1;
              ack_rise_d = 1'b0;
              state_d    = S_RDATA_ACK;
            end
          end else if (scl_fall) begin
            sda_d   = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              state_d = S_IDLE;
              sda_d   = 1'b1;
            end else begin
              ack_rise_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_d = 1'b1;
            end else begin
              ack_rise_d = 1'b0;
              bit_cnt_d  = 3'd0;
              state_d    = S_RDATA;
              sda_d      = rd_byte[7];
              shift_d    = {rd_byte[6:0], 1'b0};
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= '0;
      ptr_q       <= 8'd0;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      ack_rise_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
`ifdef I2C_TARGET_READBACK_EN
      rw_q        <= 1'b0;
`endif
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_q       <= sda_d;
      busy_q      <= busy_d;
      ack_rise_q  <= ack_rise_d;
      wr_strobe_q <= wr_en;
`ifdef I2C_TARGET_READBACK_EN
      rw_q        <= rw_d;
`endif
      if (wr_en) begin
        // Whole byte lands in one cycle, so fabric never sees a partial value.
        regs_q[ptr_q[IW-1:0]] <= byte_in;
        wr_index_q            <= ptr_q[IW-1:0];
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[8*k +: 8] = regs_q[k];
  end

  assign i2c_scl_o = 1'b1;
  assign i2c_scl_t = 1'b1;
  assign i2c_sda_o = sda_q;
  assign i2c_sda_t = sda_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bench for i2c_target_regs. A bit-banged I2C master drives the open-drain
// bus; expected register writes are queued as {index, data} when a data byte
// is sent and popped by a monitor on each wr_strobe. Read data is queued
// before a read and popped as bytes arrive.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;
  localparam int NUM_REGS   = 16;
  localparam int FILTER_LEN = 4;
  localparam int IW         = 4;
  localparam int Q          = 10;   // quarter SCL period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus and DUT ----------------
  logic                  m_scl, m_sda;
  logic                  scl_bus, sda_bus;
  logic                  dut_scl_o, dut_scl_t, dut_sda_o, dut_sda_t;
  logic [NUM_REGS*8-1:0] regs_o;
  logic                  wr_strobe;
  logic [IW-1:0]         wr_index;
  logic                  busy;

  assign scl_bus = m_scl;
  assign sda_bus = m_sda & dut_sda_o;

  i2c_target_regs #(.DEV_ADDR(7'h50), .NUM_REGS(NUM_REGS), .FILTER_LEN(FILTER_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2c_scl_i (scl_bus),
    .i2c_scl_o (dut_scl_o),
    .i2c_scl_t (dut_scl_t),
    .i2c_sda_i (sda_bus),
    .i2c_sda_o (dut_sda_o),
    .i2c_sda_t (dut_sda_t),
    .regs_o    (regs_o),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  int                 tests_run;
  int                 tests_failed;
  logic [IW+7:0]      exp_q[$];
  logic [7:0]         rd_exp_q[$];
  logic [7:0]         exp_regs [NUM_REGS];
  logic               watch_busy;
  int                 busy_low_cnt;

  function automatic logic [NUM_REGS*8-1:0] model_flat();
    logic [NUM_REGS*8-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = exp_regs[k];
    return f;
  endfunction

  // Write-strobe monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    logic [IW+7:0] exp_w, got_w;
    if (!rst && wr_strobe === 1'b1) begin
      tests_run++;
      got_w = {wr_index, regs_o[8*wr_index +: 8]};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wr_strobe_unexpected: got idx/data %h, none queued", got_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          tests_failed++;
          $display("FAIL wr_strobe_data: got idx/data %h, want %h", got_w, exp_w);
        end
      end
    end
    if (watch_busy && busy !== 1'b1) busy_low_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_scl = 1'b0; wait_q(Q);
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic i2c_stop();
    m_scl = 1'b0;
    m_sda = 1'b0; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    m_sda = 1'b1; wait_q(2*Q);
  endtask

  // Send the top n bits of b MSB first; glitch_bit inserts a short SCL low
  // pulse during the high phase of that bit.
  task automatic send_bits(input logic [7:0] b, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      m_sda = b[7-i]; wait_q(Q);
      m_scl = 1'b1;
      if (i == glitch_bit) begin
        wait_q(Q);
        m_scl = 1'b0; wait_q(FILTER_LEN - 1);
        m_scl = 1'b1; wait_q(Q);
      end else begin
        wait_q(2*Q);
      end
      m_scl = 1'b0; wait_q(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    send_bits(b, 8, glitch_bit);
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    ack = sda_bus; wait_q(Q);
    m_scl = 1'b0; wait_q(Q);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; wait_q(Q);
      m_scl = 1'b1; wait_q(Q);
      d[7-i] = sda_bus; wait_q(Q);
      m_scl = 1'b0; wait_q(Q);
    end
    m_sda = master_ack; wait_q(Q);
    m_scl = 1'b1; wait_q(2*Q);
    m_scl = 1'b0; wait_q(Q);
    m_sda = 1'b1;
  endtask

  task automatic queue_write(input int idx, input logic [7:0] d);
    exp_q.push_back({IW'(idx), d});
    exp_regs[idx] = d;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    m_scl = 1'b1; m_sda = 1'b1;
    wait_q(3);
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;
    wait_q(20);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (dut_sda_o !== 1'b1 || dut_sda_t !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_sda: got o=%b t=%b, want 1 1", dut_sda_o, dut_sda_t);
    end
    tests_run++;
    if (dut_scl_o !== 1'b1 || dut_scl_t !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_scl: got o=%b t=%b, want 1 1", dut_scl_o, dut_scl_t);
    end
    tests_run++;
    if (busy !== 1'b0 || wr_strobe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy=%b strobe=%b, want 0 0", busy, wr_strobe);
    end
    tests_run++;
    if (regs_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_regs: got %h, want 0", regs_o);
    end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] bytes [4];
    bytes[0] = 8'hA0; bytes[1] = 8'h03; bytes[2] = 8'hA5; bytes[3] = 8'h5A;
    i2c_start();
    busy_low_cnt = 0;
    watch_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) queue_write(3, 8'hA5);
      if (i == 3) queue_write(4, 8'h5A);
      send_byte(bytes[i], -1, ack);
      tests_run++;
      if (ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL write_ack%0d: got %b, want 0", i, ack);
      end
    end
    watch_busy = 1'b0;
    tests_run++;
    if (busy_low_cnt != 0) begin
      tests_failed++;
      $display("FAIL write_busy: busy low for %0d cycles, want 0", busy_low_cnt);
    end
    i2c_stop();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_busy_stop: got %b, want 0", busy);
    end
    tests_run++;
    if (regs_o !== model_flat()) begin
      tests_failed++;
      $display("FAIL write_regs: got %h, want %h", regs_o, model_flat());
    end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    i2c_start();
    send_byte(8'hA2, -1, ack);
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrong_addr_nack: got %b, want 1", ack);
    end
    i2c_stop();
    tests_run++;
    if (regs_o !== model_flat()) begin
      tests_failed++;
      $display("FAIL wrong_addr_regs: got %h, want %h", regs_o, model_flat());
    end
  endtask

  task automatic test_readback();
    logic ack;
`ifdef I2C_TARGET_READBACK_EN
    logic [7:0] d, e;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    send_byte(8'h03, -1, ack);
    i2c_start();
    send_byte(8'hA1, -1, ack);
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_addr_ack: got %b, want 0", ack);
    end
    rd_exp_q.push_back(exp_regs[3]);
    rd_exp_q.push_back(exp_regs[4]);
    for (int i = 0; i < 2; i++) begin
      read_byte((i == 1), d);
      e = rd_exp_q.pop_front();
      tests_run++;
      if (d !== e) begin
        tests_failed++;
        $display("FAIL read_byte%0d: got %h, want %h", i, d, e);
      end
    end
    tests_run++;
    if (dut_sda_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_release: got sda_o=%b, want 1", dut_sda_o);
    end
    i2c_stop();
`else
    i2c_start();
    send_byte(8'hA1, -1, ack);
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_disabled_nack: got %b, want 1", ack);
    end
    i2c_stop();
`endif
  endtask

  task automatic test_ptr_wrap();
    logic ack;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    send_byte(8'h0F, -1, ack);
    queue_write(15, 8'h11);
    send_byte(8'h11, -1, ack);
    queue_write(0, 8'h22);
    send_byte(8'h22, -1, ack);
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_ack: got %b, want 0", ack);
    end
    i2c_stop();
    tests_run++;
    if (regs_o !== model_flat()) begin
      tests_failed++;
      $display("FAIL wrap_regs: got %h, want %h", regs_o, model_flat());
    end
  endtask

  task automatic test_reset_mid();
    logic ack;
    // Reset after 4 data bits of a second data byte.
    i2c_start();
    send_byte(8'hA0, -1, ack);
    send_byte(8'h05, -1, ack);
    queue_write(5, 8'h77);
    send_byte(8'h77, -1, ack);
    send_bits(8'hE0, 4, -1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (dut_sda_o !== 1'b1 || regs_o !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got sda=%b busy=%b regs=%h, want 1 0 0", dut_sda_o, busy, regs_o);
    end
    apply_reset();
    // A full write afterwards is accepted.
    i2c_start();
    send_byte(8'hA0, -1, ack);
    send_byte(8'h09, -1, ack);
    queue_write(9, 8'h3C);
    send_byte(8'h3C, -1, ack);
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rewrite_ack: got %b, want 0", ack);
    end
    i2c_stop();
    tests_run++;
    if (regs_o !== model_flat()) begin
      tests_failed++;
      $display("FAIL reset_rewrite_regs: got %h, want %h", regs_o, model_flat());
    end
    // Reset while the target is pulling SDA low for ACK.
    i2c_start();
    send_bits(8'hA0, 8, -1);
    m_sda = 1'b1; wait_q(Q);
    m_scl = 1'b1; wait_q(Q);
    tests_run++;
    if (dut_sda_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_slot_drive: got sda_o=%b, want 0", dut_sda_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (dut_sda_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_slot_reset: got sda_o=%b, want 1", dut_sda_o);
    end
    apply_reset();
  endtask

  task automatic test_glitch();
    logic ack;
    i2c_start();
    send_byte(8'hA0, -1, ack);
    send_byte(8'h06, -1, ack);
    queue_write(6, 8'hC3);
    send_byte(8'hC3, 3, ack);
    queue_write(7, 8'h96);
    send_byte(8'h96, 6, ack);
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_ack: got %b, want 0", ack);
    end
    i2c_stop();
    tests_run++;
    if (regs_o !== model_flat()) begin
      tests_failed++;
      $display("FAIL glitch_regs: got %h, want %h", regs_o, model_flat());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tests_run = 0;
    tests_failed = 0;
    watch_busy = 1'b0;
    busy_low_cnt = 0;
    for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;

    test_reset();
    test_write();
    test_wrong_addr();
    test_readback();
    test_ptr_wrap();
    test_reset_mid();
    test_glitch();

    wait_q(20);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL strobe_missing: %0d queued writes never strobed, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) that answers the existing AXI-Lite I2C master on the shared open-drain bus. It exposes a bank of byte-wide control registers to fabric logic, for example coefficient and mode registers for the FIR under test. The block supports register-pointer writes, burst writes and burst reads with auto-increment. It runs entirely in the fabric clock domain by oversampling SCL and SDA.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START or repeated START.
- NUM_REGS, 16, number of 8-bit registers; must be a power of 2 in the range 2..256.
- FILTER_LEN, 4, number of consecutive equal synchronized samples required before a SCL or SDA level change is accepted.

Ports:
- clk  in  1  fabric clock, at least 20x the SCL rate.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- i2c_scl_i  in  1  SCL bus level.
- i2c_scl_o  out  1  constant 1; the block never stretches SCL.
- i2c_scl_t  out  1  constant 1.
- i2c_sda_i  in  1  SDA bus level.
- i2c_sda_o  out  1  0 = pull SDA low, 1 = release.
- i2c_sda_t  out  1  tristate enable; always equal to i2c_sda_o.
- regs_o  out  NUM_REGS*8  flat register bank; byte k is at [8k+7:8k].
- wr_strobe  out  1  one-cycle pulse after each byte is written into the bank.
- wr_index  out  log2(NUM_REGS)  index of the byte just written; valid while wr_strobe is high.
- busy  out  1  high from accepted START until STOP.

## Operation
Input conditioning:
- SCL and SDA each pass through a 2-flop synchronizer and then a FILTER_LEN-sample glitch filter, producing scl_f and sda_f.
- Edges are detected on the filtered signals.
- START: sda_f falls while scl_f is high. STOP: sda_f rises while scl_f is high.
- Data bits are sampled on the rising edge of scl_f.
- SDA outputs change only on the falling edge of scl_f.

State machine states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START or repeated START from any state goes to ADDR and clears the bit counter. The pointer is kept.
- ADDR: shift in 8 bits, MSB first.
  - If [7:1] equals DEV_ADDR, drive ACK in ADDR_ACK. R/W=0 then goes to PTR; R/W=1 then goes to RDATA.
  - On mismatch, release SDA (NACK) and go to IDLE.
- PTR: 8 bits load the pointer; ACK; go to WDATA.
- WDATA: 8 bits are written to regs[ptr mod NUM_REGS]; pulse wr_strobe; ACK; ptr <= ptr+1 (8-bit wrap); stay in the WDATA/WDATA_ACK loop.
- RDATA: drive regs[ptr mod NUM_REGS] MSB first; ptr increments after the byte.
  - In RDATA_ACK the block releases SDA and samples the master's ACK bit.
  - ACK (0) returns to RDATA for the next byte. NACK (1) goes to IDLE and releases SDA.
- STOP from any state: go to IDLE, release SDA, drop busy.
- A new write to a register while fabric logic is reading regs_o is safe: bytes update atomically in one cycle.

## Timing
Reset values:
- regs_o = 0, pointer = 0, state = IDLE.
- i2c_sda_o = i2c_sda_t = 1, wr_strobe = 0, busy = 0.

Latency and bus behaviour:
- A bus-level change reaches scl_f/sda_f 2+FILTER_LEN cycles after the pin changes.
- SDA drive updates 1 cycle after the falling edge of scl_f, which keeps the SDA change inside the SCL-low phase.
- wr_strobe asserts 1 cycle after the 8th data-bit rising edge. regs_o updates on the same cycle.
- busy rises 1 cycle after START is detected and falls 1 cycle after STOP is detected.

Reset and boundary conditions:
- rst asserted mid-transfer: return to reset values on the next clock. SDA is released immediately, and the bus transfer is abandoned.
- Simultaneous SCL and SDA edges within one sample are treated as a data change, never as START or STOP.

## Configuration
- I2C_TARGET_READBACK_EN defined: the read path is as described above.
- I2C_TARGET_READBACK_EN undefined:
  - An address match with R/W=1 is NACKed and the block returns to IDLE.
  - The RDATA and RDATA_ACK logic is not compiled.

## Test plan
- Write: START, 0xA0, 0x03, 0xA5, 0x5A, STOP. Required response:
  - Four ACKs.
  - regs[3]=0xA5, regs[4]=0x5A.
  - wr_strobe pulses twice, with wr_index 3 then 4.
  - busy is high for the whole frame.
- Wrong address: START, 0xA2, STOP. Required response: SDA stays released in the ACK slot (NACK), regs are unchanged, and there is no wr_strobe.
- Readback (with the macro defined): after the write test, send START, 0xA0, 0x03, repeated START, 0xA1. Required response:
  - Bytes 0xA5 then 0x5A are returned.
  - The master ACKs the first byte and NACKs the second.
  - SDA is released before STOP.
- Pointer wrap: START, 0xA0, 0x0F, 0x11, 0x22, STOP. Required response: regs[15]=0x11, regs[0]=0x22.
- Reset mid-byte: assert rst after 4 data bits of a write. Required response:
  - sda_o=1 on the next clock, regs=0, busy=0.
  - A subsequent full write is accepted normally.
- Glitch: a SCL low pulse shorter than FILTER_LEN cycles during a data byte produces no bit shift, and the byte value is unchanged.
